// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and the
// receive parity buffer: frame geometry, parity selectors and the
// parity-error helper.
package uart_pkg;

    localparam int DATA_W   = 8;
    localparam int FRAME_W  = 9;
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // One buffered entry: parity-error flag on top of the data byte.
    typedef struct packed {
        logic              perr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // A frame is in error when its ones-count disagrees with the selected
    // parity sense; oddSel flips the sense of the plain XOR reduction.
    function automatic logic framePerr(input logic [FRAME_W-1:0] frame,
                                       input logic               oddSel);
        return (^frame) ^ oddSel;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level. The reset value
// is a parameter so a caller can choose which level the output rests at
// while reset is asserted.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic stageOne_q;
    logic stageTwo_q;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stageOne_q <= RESET_VAL;
            stageTwo_q <= RESET_VAL;
        end else begin
            stageOne_q <= d;
            stageTwo_q <= stageOne_q;
        end
    end

    assign q = stageTwo_q;

endmodule

// File: rtl/rx_parity_buffer.sv
// Receive buffer sitting behind the UART receiver. Each rising edge of the
// receiver's frame-valid level pushes one frame into a first-word-fall-
// through FIFO together with its parity-error flag. A push into a full
// FIFO is dropped and raises a sticky overrun flag.
module rx_parity_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FRAME_W-1:0]       dataParityIn,
    input  logic                     readyIn,
    input  logic                     rdEn,
    input  logic                     clrOvr,
    output logic [DATA_W-1:0]        dataOut,
    output logic                     parityErrOut,
    output logic                     empty,
    output logic                     full,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic ODD_SEL = (PARITY_ODD == PAR_ODD);

    logic                 readySync;
    logic                 prev_q;
    logic                 push;
    logic                 popOk;
    logic                 pushOk;
    logic                 drop;
    logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overrun_q, overrun_d;
    entry_t               newEntry;
    entry_t               headEntry;
    logic [FRAME_W-1:0]   mem [DEPTH];

    // Resetting the synchroniser high means a level already high at reset
    // release looks "old" and cannot fake a rising edge.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) uReadySync (
        .clk (clk),
        .rst (rst),
        .d   (readyIn),
        .q   (readySync)
    );

    // Delayed copy of the synchronised level used for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= readySync;
        end
    end

    // Push/pop qualification and the entry that a push would store.
    always_comb begin
        push          = readySync & ~prev_q;
        popOk         = rdEn & ~empty;
        pushOk        = push & (~full | popOk);
        drop          = push & full & ~popOk;
        newEntry      = '0;
        newEntry.data = dataParityIn[DATA_W-1:0];
        newEntry.perr = framePerr(dataParityIn, ODD_SEL);
    end

    // Next-state for pointers, occupancy and the sticky overrun flag.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clrOvr) begin
            overrun_d = 1'b0;
        end
    end

    // Control state register; the storage array itself is left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Entry storage; a full FIFO with a same-edge pop overwrites the slot
    // that is being vacated, which is exactly where wrPtr points.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr_q] <= newEntry;
        end
    end

    // Status flags and fall-through head view, forced to zero when empty.
    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == FULL_CNT);
        overrun      = overrun_q;
        count        = count_q;
        headEntry    = mem[rdPtr_q];
        dataOut      = '0;
        parityErrOut = 1'b0;
        if (!empty) begin
            dataOut      = headEntry.data;
            parityErrOut = headEntry.perr;
        end
    end

endmodule

// File: doc/rx_parity_buffer.md
RX_PARITY_BUFFER -- requirements
Module: rx_parity_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, 2 to 64.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port clk, input, 1: system clock; one clock only, all flops on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-low.
REQ-005 SHALL have port dataParityIn, input, 9: receiver frame; [7:0] data, [8] parity bit; driven by the upstream receiver.
REQ-006 SHALL have port readyIn, input, 1: receiver frame-valid level; asynchronous to clk; high for roughly one bit time.
REQ-007 SHALL have port rdEn, input, 1: consumer pop request.
REQ-008 SHALL have port clrOvr, input, 1: clears the overrun flag.
REQ-009 SHALL have port dataOut, output, 8: head-entry data.
REQ-010 SHALL have port parityErrOut, output, 1: head-entry parity-error flag.
REQ-011 SHALL have port empty, output, 1: FIFO holds no entries.
REQ-012 SHALL have port full, output, 1: FIFO holds DEPTH entries.
REQ-013 SHALL have port overrun, output, 1: sticky flag, a frame was dropped.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1: number of occupied entries.

Function
REQ-015 SHALL pass readyIn through a two-flop synchroniser and then a third flop (prev) for edge detection.
REQ-016 SHALL assert push for exactly one cycle when the synchronised readyIn is 1 and prev is 0.
- Result: the write lands on the third rising clk edge that samples readyIn high.
REQ-017 SHALL capture dataParityIn on the push edge; dataParityIn is stable for the whole time readyIn is high.
REQ-018 SHALL compute perr = XOR of all 9 bits when PARITY_ODD=0, and perr = NOT(XOR of all 9 bits) when PARITY_ODD=1.
REQ-019 SHALL store {perr, data[7:0]} as one 9-bit entry.
REQ-020 SHALL be first-word-fall-through: when empty=0, dataOut and parityErrOut show the head entry combinationally from storage.
REQ-021 SHALL drive dataOut and parityErrOut to 0 when empty=1.
REQ-022 SHALL pop the head on a rising edge only when rdEn=1 and empty=0; rdEn while empty is ignored, with no state change.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH.
REQ-024 SHALL update count as +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-025 SHALL derive empty as count==0 and full as count==DEPTH, both registered-consistent with count.
REQ-026 SHALL handle push while full with no pop: frame dropped, storage unchanged, overrun set to 1 on that edge.
REQ-027 SHALL handle push and pop on the same edge while full: both succeed, count stays DEPTH, overrun unchanged.
REQ-028 SHALL handle push and pop on the same edge while count==1: both succeed, new entry becomes head, empty stays 0.
REQ-029 SHALL clear overrun on an edge where clrOvr=1; if a drop occurs on the same edge, set wins and overrun=1.
REQ-030 SHALL keep readyIn held high across many cycles to exactly one push; a new push needs readyIn to go low and high again.

Reset
REQ-031 SHALL, on rst low, immediately set: pointers=0, count=0, empty=1, full=0, overrun=0, dataOut=0, parityErrOut=0.
REQ-032 SHALL reset both synchroniser flops and prev to 1, so a readyIn held high through reset release produces no push.
REQ-033 SHALL discard any in-flight push when rst asserts mid-operation; storage contents are don't-care after reset.
REQ-034 SHALL release reset asynchronously; the next push is possible no earlier than the third edge after release.

Structure
REQ-035 SHALL take DATA_W=8, FRAME_W=9, PAR_EVEN=0 and PAR_ODD=1 from shared package uart_pkg, also used by the receiver and transmitter.
REQ-036 SHALL implement the two-flop synchroniser as sub-module sync_2ff, with a reset-value parameter, instantiated once.
REQ-037 SHALL implement storage as a DEPTH x 9 register array; no RAM macro.

Verification
REQ-038 SHALL cover: PARITY_ODD=0, frame 9'h0A5 (data A5, parity 0), readyIn high 16 clks -> one push, empty=0, dataOut=8'hA5, parityErrOut=0, count=1.
REQ-039 SHALL cover: PARITY_ODD=0, frame 9'h1A5 -> parityErrOut=1; same frame with PARITY_ODD=1 -> parityErrOut=0.
REQ-040 SHALL cover: DEPTH=8, frames 0x00..0x08 with no reads -> full=1 after 8 pushes; 9th push dropped; overrun=1; pops return 0x00..0x07 in order, then empty=1.
REQ-041 SHALL cover: full FIFO, rdEn=1 on the push edge -> count stays 8, overrun=0, last entry is the new frame after draining.
REQ-042 SHALL cover: rdEn pulses while empty -> count=0, no underflow, dataOut=0; clrOvr and a drop on the same edge -> overrun=1.
REQ-043 SHALL cover: rst low mid-burst with 3 entries, readyIn high at release -> empty=1, count=0, no push until readyIn toggles low and then high.
